// File: rtl/mips_prof_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_prof_pkg
// Description : Shared definitions for the multi-cycle MIPS execution
//               profiler. Holds the control-unit state codes, the opcode and
//               funct constants, the retired-instruction class encoding, the
//               readback address map and the trace tag layout.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_prof_pkg;

    // Control-unit state codes; codes above WB are reported in the UK bin.
    localparam logic [2:0] c_ST_IF = 3'd0;
    localparam logic [2:0] c_ST_ID = 3'd1;
    localparam logic [2:0] c_ST_EX = 3'd2;
    localparam logic [2:0] c_ST_MA = 3'd3;
    localparam logic [2:0] c_ST_WB = 3'd4;
    localparam logic [2:0] c_BIN_UK = 3'd5;

    localparam int c_NUM_CLASS = 9;
    localparam int c_NUM_STBIN = 6;

    // Opcode / funct fields of the instructions the profiler tells apart.
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ORI   = 6'h0d;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2b;
    localparam logic [5:0] c_FN_ADD   = 6'h20;

    typedef enum logic [3:0] {
        CLS_ADD     = 4'd0,
        CLS_R_OTHER = 4'd1,
        CLS_ADDI    = 4'd2,
        CLS_ORI     = 4'd3,
        CLS_BEQ     = 4'd4,
        CLS_J       = 4'd5,
        CLS_LW      = 4'd6,
        CLS_SW      = 4'd7,
        CLS_OTHER   = 4'd8
    } prof_class_e;

    // Readback address map.
    localparam logic [4:0] c_RB_CLS0   = 5'd0;
    localparam logic [4:0] c_RB_ST0    = 5'd9;
    localparam logic [4:0] c_RB_TOTAL  = 5'd15;
    localparam logic [4:0] c_RB_STATUS = 5'd16;

    // Fixed-width part of a trace entry. The cycle field sits between these
    // two fields in the FIFO word; its width is a module parameter, so it is
    // spliced in by the top rather than held in this struct.
    typedef struct packed {
        prof_class_e cls;
        logic [31:0] word;
    } trace_tag_t;

    function automatic prof_class_e classify(input logic [31:0] word);
        prof_class_e cls;
        case (word[31:26])
            c_OP_RTYPE: cls = (word[5:0] == c_FN_ADD) ? CLS_ADD : CLS_R_OTHER;
            c_OP_ADDI:  cls = CLS_ADDI;
            c_OP_ORI:   cls = CLS_ORI;
            c_OP_BEQ:   cls = CLS_BEQ;
            c_OP_J:     cls = CLS_J;
            c_OP_LW:    cls = CLS_LW;
            c_OP_SW:    cls = CLS_SW;
            default:    cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prof_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prof_trace_fifo
// Description : Synchronous first-word-fall-through FIFO for profiler trace
//               entries. A push into a full FIFO is dropped and sets a sticky
//               overflow flag, unless a pop frees the slot on the same edge.
//               clr empties the FIFO and clears the flag, overriding push/pop.
// Ports       : clk, reset (async, active low), clr, push, push_data, pop,
//               valid, head_data (zero while empty), full, occupancy, ovf
// Revision    : 1.0 - initial release
// ============================================================================
module prof_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 44
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic                      valid,
    output logic [DATA_W-1:0]         head_data,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      ovf
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_COUNT = (c_AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW:0]     r_count;
    logic              r_ovf;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL_COUNT);
    assign w_do_pop  = pop && !w_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !clr) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (clr) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
            if (push && !w_do_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign valid     = !w_empty;
    assign head_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign full      = w_full;
    assign occupancy = r_count;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: rtl/mips_exec_profiler.sv
`default_nettype none
// ============================================================================
// Module      : mips_exec_profiler
// Description : Non-intrusive execution profiler for the multi-cycle MIPS
//               core. Observes the control-unit state code and instruction
//               register, classifies each retired instruction and keeps
//               saturating per-class, per-state and total-cycle counters.
//               Build macro MIPS_PROF_TRACE_EN adds a trace FIFO of retired
//               instructions with their cycle cost; without it the trace
//               outputs are tied low and the status word reads zero.
// Ports       : clk, reset (async, active low), prof_en, prof_clr, uc_state,
//               instr, rd_addr -> rd_data (registered), trace_pop,
//               trace_valid, trace_data {class, cycles, instr}, trace_ovf
// Revision    : 1.0 - initial release
// ============================================================================
module mips_exec_profiler
    import mips_prof_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int CYC_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prof_en,
    input  logic                  prof_clr,
    input  logic [2:0]            uc_state,
    input  logic [31:0]           instr,
    input  logic [4:0]            rd_addr,
    output logic [CNT_W-1:0]      rd_data,
    input  logic                  trace_pop,
    output logic                  trace_valid,
    output logic [4+CYC_W+32-1:0] trace_data,
    output logic                  trace_ovf
);

    logic [2:0]       r_prev_state;
    logic             r_armed;
    logic [31:0]      r_word;
    logic [CYC_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_cls_cnt [c_NUM_CLASS];
    logic [CNT_W-1:0] r_st_cnt  [c_NUM_STBIN];
    logic [CNT_W-1:0] r_tot_cnt;
    logic [CNT_W-1:0] r_rd_data;

    logic             w_if_entry;
    logic             w_retire;
    logic [3:0]       w_class;
    logic [2:0]       w_st_bin;
    logic [CNT_W-1:0] w_status;
    logic [CNT_W-1:0] w_rd_mux;

    assign w_if_entry = (uc_state == c_ST_IF) && (r_prev_state != c_ST_IF);
    // The first IF entry only arms; an instruction that started before reset
    // or clear is never attributed. Clear also suppresses the push.
    assign w_retire   = w_if_entry && r_armed && prof_en && !prof_clr;
    assign w_class    = classify(r_word);
    assign w_st_bin   = (uc_state > c_ST_WB) ? c_BIN_UK : uc_state;

    // Instruction tracking: runs independent of prof_en so the cycle cost of
    // the instruction in flight is right when counting is switched on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev_state <= c_ST_IF;
            r_armed      <= 1'b0;
            r_word       <= '0;
            r_cyc        <= '0;
        end else begin
            r_prev_state <= uc_state;
            if (prof_clr) begin
                r_armed <= 1'b0;
            end else if (w_if_entry) begin
                r_armed <= 1'b1;
            end
            if (uc_state == c_ST_ID) begin
                r_word <= instr;
            end
            if (w_if_entry) begin
                r_cyc <= CYC_W'(1);
            end else if (r_cyc != '1) begin
                r_cyc <= r_cyc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_NUM_CLASS; i++) r_cls_cnt[i] <= '0;
            for (int i = 0; i < c_NUM_STBIN; i++) r_st_cnt[i] <= '0;
            r_tot_cnt <= '0;
        end else if (prof_clr) begin
            for (int i = 0; i < c_NUM_CLASS; i++) r_cls_cnt[i] <= '0;
            for (int i = 0; i < c_NUM_STBIN; i++) r_st_cnt[i] <= '0;
            r_tot_cnt <= '0;
        end else begin
            for (int i = 0; i < c_NUM_CLASS; i++) begin
                if (w_retire && (w_class == 4'(i)) && (r_cls_cnt[i] != '1)) begin
                    r_cls_cnt[i] <= r_cls_cnt[i] + 1'b1;
                end
            end
            if (prof_en) begin
                for (int i = 0; i < c_NUM_STBIN; i++) begin
                    if ((w_st_bin == 3'(i)) && (r_st_cnt[i] != '1)) begin
                        r_st_cnt[i] <= r_st_cnt[i] + 1'b1;
                    end
                end
                if (r_tot_cnt != '1) begin
                    r_tot_cnt <= r_tot_cnt + 1'b1;
                end
            end
        end
    end

`ifdef MIPS_PROF_TRACE_EN
    localparam int c_OCC_W = $clog2(TRACE_DEPTH) + 1;

    trace_tag_t                w_tag;
    logic [4+CYC_W+32-1:0]     w_push_data;
    logic [c_OCC_W-1:0]        w_occ;
    logic                      w_unused_full;

    assign w_tag       = '{cls: prof_class_e'(w_class), word: r_word};
    assign w_push_data = {w_tag.cls, r_cyc, w_tag.word};
    assign w_status    = CNT_W'({trace_ovf, w_occ});

    prof_trace_fifo #(
        .DEPTH  (TRACE_DEPTH),
        .DATA_W (4 + CYC_W + 32)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (prof_clr),
        .push      (w_retire),
        .push_data (w_push_data),
        .pop       (trace_pop),
        .valid     (trace_valid),
        .head_data (trace_data),
        .full      (w_unused_full),
        .occupancy (w_occ),
        .ovf       (trace_ovf)
    );
`else
    logic w_unused_trace;

    assign trace_valid    = 1'b0;
    assign trace_data     = '0;
    assign trace_ovf      = 1'b0;
    assign w_status       = '0;
    assign w_unused_trace = ^{trace_pop, r_cyc, r_word, (TRACE_DEPTH > 0)};
`endif

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < c_NUM_CLASS; i++) begin
            if (rd_addr == (c_RB_CLS0 + 5'(i))) w_rd_mux = r_cls_cnt[i];
        end
        for (int i = 0; i < c_NUM_STBIN; i++) begin
            if (rd_addr == (c_RB_ST0 + 5'(i))) w_rd_mux = r_st_cnt[i];
        end
        if (rd_addr == c_RB_TOTAL)  w_rd_mux = r_tot_cnt;
        if (rd_addr == c_RB_STATUS) w_rd_mux = w_status;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_profiler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_exec_profiler
// Description : Directed self-checking bench for mips_exec_profiler. A
//               default-width instance and a CNT_W=8 instance share stimulus;
//               the narrow one exposes counter saturation. Trace checks
//               follow the MIPS_PROF_TRACE_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_exec_profiler;

    logic        clk = 1'b0;
    logic        reset;
    logic        prof_en;
    logic        prof_clr;
    logic [2:0]  uc_state;
    logic [31:0] instr;
    logic [4:0]  rd_addr;
    logic        trace_pop;

    logic [31:0] rd_data;
    logic        trace_valid;
    logic [43:0] trace_data;
    logic        trace_ovf;

    logic [7:0]  rd_data8;
    logic        trace_valid8;
    logic [43:0] trace_data8;
    logic        trace_ovf8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_exec_profiler dut (
        .clk         (clk),
        .reset       (reset),
        .prof_en     (prof_en),
        .prof_clr    (prof_clr),
        .uc_state    (uc_state),
        .instr       (instr),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .trace_pop   (trace_pop),
        .trace_valid (trace_valid),
        .trace_data  (trace_data),
        .trace_ovf   (trace_ovf)
    );

    mips_exec_profiler #(.CNT_W(8)) dut8 (
        .clk         (clk),
        .reset       (reset),
        .prof_en     (prof_en),
        .prof_clr    (prof_clr),
        .uc_state    (uc_state),
        .instr       (instr),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data8),
        .trace_pop   (trace_pop),
        .trace_valid (trace_valid8),
        .trace_data  (trace_data8),
        .trace_ovf   (trace_ovf8)
    );

    // One core cycle: inputs apply until the next rising edge, then settle.
    task automatic step(input logic [2:0] st, input logic [31:0] w);
        uc_state = st;
        instr    = w;
        @(posedge clk);
        #1;
    endtask

    // Readback with counting disabled; rd_data is valid one edge later.
    task automatic read(input logic [4:0] a, output logic [31:0] v, output logic [7:0] v8);
        prof_en = 1'b0;
        rd_addr = a;
        @(posedge clk);
        #1;
        v  = rd_data;
        v8 = rd_data8;
    endtask

    task automatic clear();
        prof_en  = 1'b0;
        prof_clr = 1'b1;
        step(uc_state, instr);
        prof_clr = 1'b0;
    endtask

    // WB then IF with counting off: a fresh IF entry that arms the profiler
    // and restarts the cycle count without retiring anything.
    task automatic begin_instr();
        prof_en = 1'b0;
        step(3'd4, 32'h0);
        step(3'd0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [7:0]  v8;
        reset = 1'b0; prof_en = 1'b0; prof_clr = 1'b0; trace_pop = 1'b0;
        uc_state = 3'd0; instr = 32'h0; rd_addr = 5'd15;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
        checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL reset_trace_valid got=%0b exp=0", trace_valid); end
        checks++; if (trace_data !== 44'h0) begin failures++; $display("FAIL reset_trace_data got=%0h exp=0", trace_data); end
        checks++; if (trace_ovf !== 1'b0) begin failures++; $display("FAIL reset_trace_ovf got=%0b exp=0", trace_ovf); end
        reset = 1'b1;
        read(5'd15, v, v8);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_total got=%0h exp=0", v); end
    endtask

    task automatic test_add();
        logic [31:0] v;
        logic [7:0]  v8;
        int          addrs [7] = '{0, 9, 10, 11, 12, 13, 15};
        int          exps  [7] = '{1, 2, 1, 1, 0, 1, 5};
        prof_en = 1'b0;
        step(3'd4, 32'h0);
        prof_en = 1'b1;
        step(3'd0, 32'h0);
        step(3'd1, 32'h012A4020);
        step(3'd2, 32'h0);
        step(3'd4, 32'h0);
        step(3'd0, 32'h0);
        prof_en = 1'b0;
`ifdef MIPS_PROF_TRACE_EN
        checks++; if (trace_valid !== 1'b1) begin failures++; $display("FAIL add_trace_valid got=%0b exp=1", trace_valid); end
        checks++; if (trace_data !== {4'd0, 8'd4, 32'h012A4020}) begin failures++; $display("FAIL add_trace_entry got=%0h exp=%0h", trace_data, {4'd0, 8'd4, 32'h012A4020}); end
`endif
        for (int i = 0; i < 7; i++) begin
            read(5'(addrs[i]), v, v8);
            checks++; if (v !== 32'(exps[i])) begin failures++; $display("FAIL add_count addr=%0d got=%0d exp=%0d", addrs[i], v, exps[i]); end
        end
`ifdef MIPS_PROF_TRACE_EN
        read(5'd16, v, v8);
        checks++; if (v !== 32'd1) begin failures++; $display("FAIL add_status got=%0h exp=1", v); end
        trace_pop = 1'b1;
        step(3'd0, 32'h0);
        trace_pop = 1'b0;
        checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL add_pop_valid got=%0b exp=0", trace_valid); end
        trace_pop = 1'b1;
        step(3'd0, 32'h0);
        trace_pop = 1'b0;
        read(5'd16, v, v8);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL pop_empty_status got=%0h exp=0", v); end
`else
        checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL notrace_valid got=%0b exp=0", trace_valid); end
        read(5'd16, v, v8);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL notrace_status got=%0h exp=0", v); end
`endif
    endtask

    task automatic test_addi_beq();
        logic [31:0] v;
        logic [7:0]  v8;
        clear();
        begin_instr();
        prof_en = 1'b1;
        step(3'd1, 32'h21080005); step(3'd2, 32'h0); step(3'd4, 32'h0); step(3'd0, 32'h0);
        step(3'd1, 32'h1109FFFE); step(3'd2, 32'h0); step(3'd0, 32'h0);
        prof_en = 1'b0;
        read(5'd2, v, v8);
        checks++; if (v !== 32'd1) begin failures++; $display("FAIL addi_count got=%0d exp=1", v); end
        read(5'd4, v, v8);
        checks++; if (v !== 32'd1) begin failures++; $display("FAIL beq_count got=%0d exp=1", v); end
        read(5'd0, v, v8);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL add_cleared got=%0d exp=0", v); end
`ifdef MIPS_PROF_TRACE_EN
        checks++; if (trace_data !== {4'd2, 8'd4, 32'h21080005}) begin failures++; $display("FAIL addi_entry got=%0h exp=%0h", trace_data, {4'd2, 8'd4, 32'h21080005}); end
        trace_pop = 1'b1; step(3'd0, 32'h0); trace_pop = 1'b0;
        checks++; if (trace_data !== {4'd4, 8'd3, 32'h1109FFFE}) begin failures++; $display("FAIL beq_entry got=%0h exp=%0h", trace_data, {4'd4, 8'd3, 32'h1109FFFE}); end
        trace_pop = 1'b1; step(3'd0, 32'h0); trace_pop = 1'b0;
        checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL addi_beq_drain got=%0b exp=0", trace_valid); end
`endif
    endtask

    task automatic test_classes();
        logic [31:0] v;
        logic [7:0]  v8;
        logic [31:0] words [6] = '{32'h012A4022, 32'h35080001, 32'h08000010,
                                   32'h8D090004, 32'hAD090004, 32'h3C010001};
        int          addrs [6] = '{1, 3, 5, 6, 7, 8};
        clear();
        begin_instr();
        prof_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(3'd1, words[i]); step(3'd2, 32'h0); step(3'd4, 32'h0); step(3'd0, 32'h0);
        end
        prof_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            read(5'(addrs[i]), v, v8);
            checks++; if (v !== 32'd1) begin failures++; $display("FAIL class_count addr=%0d got=%0d exp=1", addrs[i], v); end
        end
        read(5'd2, v, v8);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL class_addi_zero got=%0d exp=0", v); end
        read(5'd9, v, v8);
        checks++; if (v !== 32'd6) begin failures++; $display("FAIL class_if_cycles got=%0d exp=6", v); end
        read(5'd15, v, v8);
        checks++; if (v !== 32'd24) begin failures++; $display("FAIL class_total got=%0d exp=24", v); end
        read(5'd20, v, v8);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL unmapped_addr got=%0h exp=0", v); end
`ifdef MIPS_PROF_TRACE_EN
        read(5'd16, v, v8);
        checks++; if (v !== 32'd6) begin failures++; $display("FAIL class_status got=%0h exp=6", v); end
`endif
    endtask

`ifdef MIPS_PROF_TRACE_EN
    task automatic test_overflow();
        logic [31:0] v;
        logic [7:0]  v8;
        clear();
        begin_instr();
        prof_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(3'd1, 32'h20000000 + 32'(i)); step(3'd2, 32'h0); step(3'd4, 32'h0); step(3'd0, 32'h0);
        end
        prof_en = 1'b0;
        read(5'd16, v, v8);
        checks++; if (v !== 32'h30) begin failures++; $display("FAIL ovf_status got=%0h exp=30", v); end
        checks++; if (trace_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", trace_ovf); end
        checks++; if (trace_data !== {4'd2, 8'd4, 32'h20000000}) begin failures++; $display("FAIL ovf_head got=%0h exp=%0h", trace_data, {4'd2, 8'd4, 32'h20000000}); end
        prof_en = 1'b1;
        step(3'd1, 32'h20000011); step(3'd2, 32'h0); step(3'd4, 32'h0);
        trace_pop = 1'b1;
        step(3'd0, 32'h0);
        trace_pop = 1'b0;
        prof_en = 1'b0;
        read(5'd16, v, v8);
        checks++; if (v !== 32'h30) begin failures++; $display("FAIL full_push_pop_status got=%0h exp=30", v); end
        checks++; if (trace_data !== {4'd2, 8'd4, 32'h20000001}) begin failures++; $display("FAIL full_push_pop_head got=%0h exp=%0h", trace_data, {4'd2, 8'd4, 32'h20000001}); end
        trace_pop = 1'b1; step(3'd0, 32'h0); trace_pop = 1'b0;
        read(5'd16, v, v8);
        checks++; if (v !== 32'h2F) begin failures++; $display("FAIL pop_only_status got=%0h exp=2f", v); end
    endtask
`else
    task automatic test_no_trace();
        logic [31:0] v;
        logic [7:0]  v8;
        clear();
        begin_instr();
        for (int i = 0; i < 3; i++) begin
            prof_en = 1'b1;
            step(3'd1, 32'h21080005); step(3'd2, 32'h0); step(3'd4, 32'h0); step(3'd0, 32'h0);
            prof_en = 1'b0;
            step(3'd0, 32'h0);
            checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL notrace_valid_%0d got=%0b exp=0", i, trace_valid); end
        end
        read(5'd2, v, v8);
        checks++; if (v !== 32'd3) begin failures++; $display("FAIL notrace_addi got=%0d exp=3", v); end
        read(5'd16, v, v8);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL notrace_status2 got=%0h exp=0", v); end
        checks++; if ({trace_ovf, trace_data} !== 45'h0) begin failures++; $display("FAIL notrace_outputs got=%0h exp=0", {trace_ovf, trace_data}); end
    endtask
`endif

    task automatic test_saturation();
        logic [31:0] v;
        logic [7:0]  v8;
        clear();
        prof_en = 1'b1;
        repeat (300) step(3'd2, 32'h0);
        read(5'd15, v, v8);
        checks++; if (v8 !== 8'd255) begin failures++; $display("FAIL sat_total8 got=%0d exp=255", v8); end
        checks++; if (v !== 32'd300) begin failures++; $display("FAIL sat_total32 got=%0d exp=300", v); end
        read(5'd11, v, v8);
        checks++; if (v8 !== 8'd255) begin failures++; $display("FAIL sat_ex8 got=%0d exp=255", v8); end
        read(5'd9, v, v8);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL sat_if_zero got=%0d exp=0", v); end
    endtask

    task automatic test_unknown();
        logic [31:0] v;
        logic [7:0]  v8;
        clear();
        prof_en = 1'b1;
        repeat (3) step(3'd6, 32'h0);
        read(5'd14, v, v8);
        checks++; if (v !== 32'd3) begin failures++; $display("FAIL uk_bin got=%0d exp=3", v); end
        checks++; if (v8 !== 8'd3) begin failures++; $display("FAIL uk_bin8 got=%0d exp=3", v8); end
        read(5'd15, v, v8);
        checks++; if (v !== 32'd3) begin failures++; $display("FAIL uk_total got=%0d exp=3", v); end
    endtask

    task automatic test_clear_mid();
        logic [31:0] v;
        logic [7:0]  v8;
        int          nz;
        clear();
        begin_instr();
        prof_en = 1'b1;
        step(3'd1, 32'h012A4020);
        step(3'd2, 32'h0);
        prof_clr = 1'b1;
        step(3'd4, 32'h0);
        prof_clr = 1'b0;
        nz = 0;
        for (int a = 0; a < 32; a++) begin
            read(5'(a), v, v8);
            if (v !== 32'd0) nz++;
        end
        checks++; if (nz !== 0) begin failures++; $display("FAIL clr_all_zero nonzero_reads=%0d exp=0", nz); end
        prof_en = 1'b1;
        step(3'd0, 32'h0);
        read(5'd0, v, v8);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL clr_first_if got=%0d exp=0", v); end
        read(5'd9, v, v8);
        checks++; if (v !== 32'd1) begin failures++; $display("FAIL clr_if_cycle got=%0d exp=1", v); end
        prof_en = 1'b1;
        step(3'd1, 32'h012A4020); step(3'd2, 32'h0); step(3'd4, 32'h0); step(3'd0, 32'h0);
        read(5'd0, v, v8);
        checks++; if (v !== 32'd1) begin failures++; $display("FAIL clr_second_if got=%0d exp=1", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic [7:0]  v8;
        rd_addr = 5'd0;
        begin_instr();
        prof_en = 1'b1;
        step(3'd1, 32'h012A4020);
        step(3'd2, 32'h0);
        reset = 1'b0;
        #1;
        checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL async_reset_rd got=%0h exp=0", rd_data); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        prof_en = 1'b1;
        step(3'd4, 32'h0);
        step(3'd0, 32'h0);
        read(5'd0, v, v8);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_no_retire got=%0d exp=0", v); end
        read(5'd9, v, v8);
        checks++; if (v !== 32'd1) begin failures++; $display("FAIL reset_if_cycle got=%0d exp=1", v); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi_beq();
        test_classes();
`ifdef MIPS_PROF_TRACE_EN
        test_overflow();
`else
        test_no_trace();
`endif
        test_saturation();
        test_unknown();
        test_clear_mid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_exec_profiler.md
# mips_exec_profiler

Non-intrusive execution profiler for the multi-cycle MIPS core. It watches the control-unit state code and the instruction register, and classifies every retired instruction by opcode/funct. It keeps saturating per-class, per-state and total-cycle counters, and, optionally, a trace FIFO of retired instructions with their cycle cost. It sits beside the control unit inside the multi-cycle top, observes only, and never drives the datapath.

## Interface
- `CNT_W`, 32: width of every event/cycle counter and of `rd_data` (8..64)
- `TRACE_DEPTH`, 16: trace FIFO entries, power of two, 2..256
- `CYC_W`, 8: width of per-instruction cycle count in a trace entry
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-low reset
- `prof_en`  in  1  counting/tracing enable
- `prof_clr`  in  1  synchronous clear of counters, flags and FIFO
- `uc_state`  in  3  control-unit state code: 0 IF, 1 ID, 2 EX, 3 MA, 4 WB, 5..7 unknown
- `instr`  in  32  instruction register contents
- `rd_addr`  in  5  counter readback select
- `rd_data`  out  CNT_W  registered readback value
- `trace_pop`  in  1  consume FIFO head
- `trace_valid`  out  1  FIFO not empty
- `trace_data`  out  4+CYC_W+32  head entry {class, cycles, instr}, first-word-fall-through
- `trace_ovf`  out  1  sticky overflow flag

## Operation
- Classes (4-bit): 0 ADD (op 0, funct 0x20), 1 R_OTHER (op 0, other funct), 2 ADDI (0x08), 3 ORI (0x0d), 4 BEQ (0x04), 5 J (0x02), 6 LW (0x23), 7 SW (0x2b), 8 OTHER.
- `prev_state` register tracks `uc_state` every cycle regardless of `prof_en`.
- IF entry: `uc_state`==0 and `prev_state`!=0. The first IF entry after reset or clear sets `armed`.
- Captured word: `instr` sampled on every cycle with `uc_state`==1; the last ID-cycle value is used.
- Instruction cycle counter: loads 1 on the IF-entry cycle, otherwise increments and saturates at 2^CYC_W-1.
- Retirement: IF entry while `armed` and `prof_en`.
  - Increments the class counter of the captured word.
  - Pushes {class, cycle counter value before reload, word} to the FIFO.
- Per-state counters: +1 per cycle in that state while `prof_en`; codes 5..7 go to the UK bin. Total-cycle counter: +1 per cycle while `prof_en`.
- All counters saturate at 2^CNT_W-1 and never wrap.
- Readback map:
  - 0..8 class counts
  - 9..14 state cycles IF, ID, EX, MA, WB, UK
  - 15 total cycles
  - 16 status: {trace_ovf, FIFO occupancy}, zero-extended
  - 17..31 read 0
- `prof_clr` zeros all counters, FIFO and `trace_ovf`, and clears `armed`. The in-flight instruction is not counted.

## Timing
- Reset values: `rd_data`=0, `trace_valid`=0, `trace_data`=0, `trace_ovf`=0, `armed`=0, `prev_state`=0.
- `rd_data` shows the addressed value as of the previous edge; latency is 1 cycle.
- Counter and FIFO updates land on the edge that ends the triggering cycle. A retirement is visible in `rd_data`/`trace_valid` 2 cycles / 1 cycle after the IF-entry cycle.
- Pop: `trace_pop`&&`trace_valid` advances the head at the edge. Pop while empty is ignored.
- Push when full without pop: entry dropped, `trace_ovf` set. Push and pop in the same cycle when full: both happen, no overflow. Push and pop when empty: entry written, `trace_valid` rises next cycle.
- `prof_clr` has priority over every same-cycle increment or push.
- Reset asserted mid-instruction: immediate clear. The next retirement requires a fresh IF entry after deassertion.

## Configuration
- `MIPS_PROF_TRACE_EN` defined: trace FIFO, `trace_ovf` and the occupancy status field are present.
- `MIPS_PROF_TRACE_EN` undefined: no FIFO storage. `trace_valid`, `trace_data`, `trace_ovf` are tied 0, `trace_pop` is ignored, status reads 0. Counters are unaffected.

## Structure
- Package `mips_prof_pkg`:
  - state codes and class enum
  - opcode/funct constants
  - readback address localparams
  - trace entry packed struct
- Sub-module `prof_trace_fifo`: parametrised synchronous FWFT FIFO with full/empty/occupancy and drop-on-full overflow.
- Classifier and counters live in the top module.

## Test plan
- Reset, then IF, ID, EX, WB, IF with `instr`=0x012A4020 (add): class 0 count = 1, IF cycles = 2, ID = EX = WB = 1, trace entry {0, 4, 0x012A4020}.
- `addi` (0x21080005) over IF, ID, EX, WB, IF followed by `beq` over IF, ID, EX, IF: class 2 = 1, class 4 = 1, entry cycles 4 then 3.
- 17 retirements with `TRACE_DEPTH`=16 and no pops: occupancy 16, `trace_ovf`=1, head = first instruction. A pop on a later retirement cycle while full: no further overflow.
- `CNT_W`=8, `prof_en`=1 for 300 cycles: total reads 255.
- `uc_state`=6 for 3 cycles: UK bin = 3. `prof_clr` mid-instruction: all reads 0, first IF entry after clear yields no retirement, the next one does.
- Build without `MIPS_PROF_TRACE_EN`: retirements update class counters, `trace_valid` stays 0, address 16 reads 0.
